// File: rtl/online_div_sequencer_if.sv
// rtl/online_div_sequencer_if.sv - command, digit-stream and status bundle for the online divider sequencer
// ONLINE_DIV_STATS_EN adds the stall_cnt status field.
interface online_div_sequencer_if;
    logic       start;
    logic       abort;
    logic       hold;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] x_digit;
    logic [1:0] d_digit;
    logic [1:0] x_digit_o;
    logic [1:0] d_digit_o;
    logic [1:0] q_value;
    logic       q_valid;
    logic       q_ready;
    logic [1:0] q_digit;
    logic [8:0] cnt_master;
    logic       busy;
    logic       done;
`ifdef ONLINE_DIV_STATS_EN
    logic [15:0] stall_cnt;

    modport slave (
        input  start, abort, hold, in_valid, x_digit, d_digit, q_value, q_ready,
        output in_ready, x_digit_o, d_digit_o, q_valid, q_digit, cnt_master, busy, done, stall_cnt
    );
    modport master (
        output start, abort, hold, in_valid, x_digit, d_digit, q_value, q_ready,
        input  in_ready, x_digit_o, d_digit_o, q_valid, q_digit, cnt_master, busy, done, stall_cnt
    );
`else
    modport slave (
        input  start, abort, hold, in_valid, x_digit, d_digit, q_value, q_ready,
        output in_ready, x_digit_o, d_digit_o, q_valid, q_digit, cnt_master, busy, done
    );
    modport master (
        output start, abort, hold, in_valid, x_digit, d_digit, q_value, q_ready,
        input  in_ready, x_digit_o, d_digit_o, q_valid, q_digit, cnt_master, busy, done
    );
`endif
endinterface

// File: rtl/online_div_sequencer.sv
// rtl/online_div_sequencer.sv - MSD-first online divider sequencer: sub-cycle counter, digit handshakes, online delay
// ONLINE_DIV_STATS_EN adds a saturating stall cycle counter.
module online_div_sequencer #(
    parameter int NDIGITS = 32,
    parameter int DELTA   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    online_div_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_PRELOAD,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [6:0] J_PRELOAD_END = 7'(DELTA - 1);
    localparam logic [6:0] J_RUN_END     = 7'(NDIGITS - 1);
    localparam logic [6:0] J_FLUSH_END   = 7'(NDIGITS + DELTA - 1);

    state_t     r_state;
    logic [8:0] r_cnt;
    logic [1:0] r_x_digit;
    logic [1:0] r_d_digit;

    logic [6:0] w_j;
    logic [1:0] w_phase;
    logic       w_busy;
    logic       w_need_in;
    logic       w_need_out;
    logic       w_adv;
    logic       w_in_xfer;
    logic       w_iter_end;

    assign w_j        = r_cnt[8:2];
    assign w_phase    = r_cnt[1:0];
    assign w_busy     = (r_state == S_PRELOAD) || (r_state == S_RUN) || (r_state == S_FLUSH);
    assign w_need_in  = ((r_state == S_PRELOAD) || (r_state == S_RUN)) && (w_phase == 2'd0);
    assign w_need_out = ((r_state == S_RUN) || (r_state == S_FLUSH)) && (w_phase == 2'd3);
    assign w_adv      = w_busy && !bus.hold && (!w_need_in || bus.in_valid) && (!w_need_out || bus.q_ready);
    assign w_in_xfer  = w_need_in && !bus.hold && bus.in_valid;
    assign w_iter_end = w_adv && (w_phase == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_x_digit <= '0;
            r_d_digit <= '0;
        end else if (bus.abort && (r_state != S_IDLE)) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_x_digit <= '0;
            r_d_digit <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (bus.start) r_state <= S_PRELOAD;
                end
                S_PRELOAD, S_RUN, S_FLUSH: begin
                    if (w_adv) r_cnt <= r_cnt + 9'd1;
                    if (w_in_xfer) begin
                        r_x_digit <= bus.x_digit;
                        r_d_digit <= bus.d_digit;
                    end
                    if (w_iter_end) begin
                        if (r_state == S_PRELOAD && w_j == J_PRELOAD_END) begin
                            r_state <= S_RUN;
                        end else if (r_state == S_RUN && w_j == J_RUN_END) begin
                            // inputs are exhausted: the datapath is fed zero digits while it drains
                            r_state   <= S_FLUSH;
                            r_x_digit <= '0;
                            r_d_digit <= '0;
                        end else if (r_state == S_FLUSH && w_j == J_FLUSH_END) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = w_need_in && !bus.hold;
    assign bus.q_valid    = w_need_out && !bus.hold;
    assign bus.q_digit    = bus.q_value;
    assign bus.x_digit_o  = r_x_digit;
    assign bus.d_digit_o  = r_d_digit;
    assign bus.cnt_master = r_cnt;
    assign bus.busy       = w_busy;
    assign bus.done       = (r_state == S_DONE);

`ifdef ONLINE_DIV_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_stall_cnt <= '0;
        end else if (w_busy && !w_adv && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_online_div_sequencer.sv
// tb/tb_online_div_sequencer.sv - directed bench with an advance-count model of the online divider sequencer
module tb_online_div_sequencer;
    localparam int N = 8;
    localparam int D = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    online_div_sequencer_if bus ();

    online_div_sequencer #(.NDIGITS(N), .DELTA(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: an operation is a count m of advances; everything follows from m.
    bit         m_active = 0;
    bit         m_done   = 0;
    int         m_cnt    = 0;
    logic [1:0] m_x      = 0;
    logic [1:0] m_d      = 0;
    int         m_stall  = 0;
    int         ncyc     = 0;
    int         t_start  = 0;
    int         done_lat = -1;
    int         busy_op  = 0;
    bit         done_seen = 0;
    int         in_log[$];
    int         q_log[$];

    initial begin
        bit need_in, need_out, adv;
        forever begin
            @(negedge clk);
            ncyc++;
            need_in  = m_active && (m_cnt % 4 == 0) && (m_cnt / 4 < N);
            need_out = m_active && (m_cnt % 4 == 3) && (m_cnt / 4 >= D);
            adv      = m_active && !bus.hold && (!need_in || bus.in_valid) && (!need_out || bus.q_ready);

            check("busy", bus.busy, m_active);
            check("done", bus.done, m_done);
            check("cnt_master", bus.cnt_master, m_cnt);
            check("in_ready", bus.in_ready, need_in && !bus.hold);
            check("q_valid", bus.q_valid, need_out && !bus.hold);
            check("x_digit_o", bus.x_digit_o, m_x);
            check("d_digit_o", bus.d_digit_o, m_d);
            check("q_digit", bus.q_digit, bus.q_value);
`ifdef ONLINE_DIV_STATS_EN
            check("stall_cnt", bus.stall_cnt, m_stall);
`endif
            if (bus.in_valid && bus.in_ready) in_log.push_back(int'(bus.cnt_master));
            if (bus.q_valid && bus.q_ready) q_log.push_back(int'(bus.cnt_master));
            if (bus.busy) busy_op++;
            if (bus.done) begin
                done_lat  = ncyc - t_start;
                done_seen = 1;
            end

            if (rst) begin
                m_active = 0; m_done = 0; m_cnt = 0; m_x = 0; m_d = 0; m_stall = 0;
            end else begin
                if (m_active && !adv && m_stall < 65535) m_stall++;
                if (m_done) begin
                    m_done = 0;
                    m_cnt  = 0;
                end else if (m_active && bus.abort) begin
                    m_active = 0; m_cnt = 0; m_x = 0; m_d = 0;
                end else if (!m_active) begin
                    if (bus.start) begin
                        m_active = 1; m_cnt = 0; m_stall = 0; t_start = ncyc;
                        in_log.delete(); q_log.delete(); busy_op = 0; done_seen = 0; done_lat = -1;
                    end
                end else if (adv) begin
                    if (need_in) begin
                        m_x = bus.x_digit;
                        m_d = bus.d_digit;
                    end
                    m_cnt++;
                    if (m_cnt == N * 4) begin
                        m_x = 0; m_d = 0;
                    end
                    if (m_cnt == (N + D) * 4) begin
                        m_active = 0;
                        m_done   = 1;
                    end
                end
            end
        end
    end

    // Digit source: walks through {0, +1, -1}; q_value is frozen while a quotient digit is pending.
    initial begin
        logic [1:0] enc [3];
        int k;
        enc[0] = 2'b00; enc[1] = 2'b01; enc[2] = 2'b11;
        k = 0;
        bus.x_digit = 2'b00; bus.d_digit = 2'b01; bus.q_value = 2'b11;
        forever begin
            @(posedge clk);
            #1;
            k++;
            bus.x_digit = enc[k % 3];
            bus.d_digit = enc[(k + 1) % 3];
            if (!(bus.q_valid && !bus.q_ready)) bus.q_value = enc[(k / 2) % 3];
        end
    end

    task automatic launch();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    task automatic wait_cnt(input int v);
        bit ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk); #1;
            if (bus.busy && bus.cnt_master == 9'(v)) ok = 1;
        end
        check($sformatf("reach_cnt_%0d", v), ok, 1);
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        bit ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk); #1;
            if (bus.done) ok = 1;
        end
        check({name, "_done_seen"}, ok, 1);
        @(negedge clk); #1;
        check({name, "_done_latency"}, done_lat, exp_lat);
        check({name, "_in_xfers"}, in_log.size(), N);
        check({name, "_q_xfers"}, q_log.size(), N);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 0; bus.abort = 0; bus.hold = 0; bus.in_valid = 1; bus.q_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_busy", bus.busy, 0);
        check("reset_cnt", bus.cnt_master, 0);
        check("reset_in_ready", bus.in_ready, 0);
        check("reset_q_valid", bus.q_valid, 0);
        check("reset_done", bus.done, 0);

        // unstalled operation
        launch();
        wait_done("plain", 45);
        check("plain_busy_cycles", busy_op, 44);
        if (in_log.size() == N && q_log.size() == N) begin
            check("plain_first_in_cnt", in_log[0], 0);
            check("plain_last_in_cnt", in_log[N-1], 28);
            check("plain_first_q_cnt", q_log[0], 15);
            check("plain_last_q_cnt", q_log[N-1], 43);
        end

        // input starvation at cnt 8
        launch();
        wait_cnt(8);
        bus.in_valid = 0;
        repeat (5) @(posedge clk);
        #1 bus.in_valid = 1;
        wait_done("in_stall", 50);
`ifdef ONLINE_DIV_STATS_EN
        check("in_stall_stall_cnt", bus.stall_cnt, 5);
`endif

        // hold in RUN
        launch();
        wait_cnt(17);
        bus.hold = 1;
        repeat (3) @(posedge clk);
        #1 bus.hold = 0;
        wait_done("hold", 48);

        // consumer back-pressure on the first quotient digit
        launch();
        wait_cnt(15);
        bus.q_ready = 0;
        repeat (4) @(posedge clk);
        #1 bus.q_ready = 1;
        wait_done("q_stall", 49);

        // abort, then a clean restart
        launch();
        wait_cnt(20);
        bus.abort = 1;
        @(posedge clk); #1 bus.abort = 0;
        check("abort_busy", bus.busy, 0);
        check("abort_cnt", bus.cnt_master, 0);
        repeat (3) @(posedge clk);
        #1 check("abort_no_done", done_seen, 0);
        launch();
        wait_done("after_abort", 45);
        check("after_abort_busy_cycles", busy_op, 44);

        // start while busy is ignored, then reset mid-operation
        launch();
        wait_cnt(5);
        bus.start = 1;
        @(posedge clk); #1 bus.start = 0;
        check("restart_ignored_cnt", bus.cnt_master, 6);
        wait_cnt(30);
        rst = 1;
        @(posedge clk); #1 rst = 0;
        check("midrst_busy", bus.busy, 0);
        check("midrst_cnt", bus.cnt_master, 0);
        check("midrst_x", bus.x_digit_o, 0);
        check("midrst_d", bus.d_digit_o, 0);
        repeat (3) @(posedge clk);
        #1 check("midrst_no_done", done_seen, 0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
